// File: rtl/weight_read_sequencer_if.sv
// Bus bundle for weight_read_sequencer: activation stream in, weight memory
// read port, and the aligned {weight, input} beat stream out to the MAC.
// The master modport is the sequencer side; slave is the surrounding fabric.
interface weight_read_sequencer_if #(
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned addressWidth = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [dataWidth-1:0]    in_data;
  logic                    mem_ren;
  logic [addressWidth-1:0] mem_radd;
  logic [dataWidth-1:0]    mem_wout;
  logic                    mac_valid;
  logic [dataWidth-1:0]    mac_weight;
  logic [dataWidth-1:0]    mac_input;
  logic                    mac_last;

  modport master (
    input  in_valid, in_data, mem_wout,
    output in_ready, mem_ren, mem_radd, mac_valid, mac_weight, mac_input, mac_last
  );

  modport slave (
    output in_valid, in_data, mem_wout,
    input  in_ready, mem_ren, mem_radd, mac_valid, mac_weight, mac_input, mac_last
  );
endinterface

// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer: walks one neuron's weight memory (1-cycle registered
// read) in lockstep with the incoming activation stream and emits aligned
// {weight, input} beats to the MAC, flagging the last beat and pulsing done.
// Optional feature: define WSEQ_STALL_CNT_EN to add a 16-bit saturating
// stall_cnt output counting RUN cycles without an activation beat.
module weight_read_sequencer #(
  parameter int unsigned numWeight    = 30,
  parameter int unsigned addressWidth = $clog2(numWeight),
  parameter int unsigned dataWidth    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef WSEQ_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  weight_read_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StLast, StDone} state_e;

  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    accept;
  logic                    at_last;
  logic                    mac_valid_q;
  logic                    mac_last_q;
  logic                    done_q;
  logic [dataWidth-1:0]    mac_input_q;

  // Handshake and output decode; weight passes straight through because the
  // memory already registers its read data, which lines it up with mac_input.
  always_comb begin
    accept         = bus.in_valid & (state_q == StRun);
    at_last        = (addr_q == LastAddr);
    bus.in_ready   = (state_q == StRun);
    bus.mem_ren    = accept;
    bus.mem_radd   = addr_q;
    bus.mac_valid  = mac_valid_q;
    bus.mac_last   = mac_last_q;
    bus.mac_input  = mac_input_q;
    bus.mac_weight = bus.mem_wout;
    busy           = (state_q != StIdle);
    done           = done_q;
  end

  // Next-state and address counter
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (at_last) begin
            state_d = StLast;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + addressWidth'(1);
          end
        end
      end
      StLast:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // MAC beat registers: one cycle behind the accepted read, matching memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_input_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mac_valid_q <= accept;
      mac_last_q  <= accept & at_last;
      if (accept) begin
        mac_input_q <= bus.in_data;
      end
      done_q <= (state_d == StDone);
    end
  end

`ifdef WSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of RUN cycles without a beat; held after the run ends
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StRun) && !bus.in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Self-checking bench for weight_read_sequencer with a behavioural weight ROM
// (1-cycle registered read) and a scoreboard of expected MAC beats.
module tb_weight_read_sequencer;
  localparam int NW = 30;
  localparam int AW = 5;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef WSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  weight_read_sequencer_if #(.dataWidth(DW), .addressWidth(AW)) bus ();

  weight_read_sequencer #(
    .numWeight   (NW),
    .addressWidth(AW),
    .dataWidth   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
`ifdef WSEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Weight ROM model with registered read
  logic [DW-1:0] rom [0:NW-1];
  logic [DW-1:0] wout_q;
  always @(posedge clk) begin
    if (bus.mem_ren === 1'b1) wout_q <= rom[bus.mem_radd];
  end
  assign bus.mem_wout = wout_q;

  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];
  int    exp_addr = 0;
  int    mon_beats = 0;

  // Scoreboard: push on accepted read, pop on MAC beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus.mac_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat got w=%h d=%h l=%b required no beat",
                   bus.mac_weight, bus.mac_input, bus.mac_last);
        end else begin
          e = sb.pop_front();
          mon_beats++;
          if ({bus.mac_weight, bus.mac_input, bus.mac_last} !== {e.w, e.d, e.last}) begin
            errors++;
            $display("FAIL sb_beat got w=%h d=%h l=%b required w=%h d=%h l=%b",
                     bus.mac_weight, bus.mac_input, bus.mac_last, e.w, e.d, e.last);
          end
        end
      end
      if (rst === 1'b1) begin
        sb.delete();
        exp_addr = 0;
      end else if (bus.mem_ren === 1'b1) begin
        checks++;
        if (bus.mem_radd !== AW'(exp_addr)) begin
          errors++;
          $display("FAIL sb_radd got %0d required %0d", bus.mem_radd, exp_addr);
        end
        e.w    = rom[exp_addr];
        e.d    = bus.in_data;
        e.last = (exp_addr == NW - 1);
        sb.push_back(e);
        exp_addr = (exp_addr == NW - 1) ? 0 : exp_addr + 1;
      end
    end
  end

  // Drives one run: start pulse, then beats with in_data=k+1 for k accepted so far.
  // Stalls of ln cycles follow the st-th accepted beat. Optional start pulse at
  // beat restart_at and reset at beat rst_at (returns right after the reset cycle).
  task automatic run_seq(input int st0, input int ln0, input int st1, input int ln1,
                         input int st2, input int ln2, input int restart_at,
                         input int rst_at, output int n_done, output int n_cyc,
                         output int bad_ren);
    int k = 0;
    int stall_left = 0;
    bit restarted = 0;
    n_done  = 0;
    n_cyc   = -1;
    bad_ren = 0;
    @(posedge clk); #1;
    start = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
    @(negedge clk);
    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
      start = (restart_at >= 0 && k == restart_at && !restarted);
      if (start) restarted = 1;
      bus.in_valid = (stall_left == 0);
      bus.in_data  = DW'(k + 1);
      if (rst_at >= 0 && k == rst_at) rst = 1'b1;
      @(negedge clk);
      if (!bus.in_valid && bus.mem_ren !== 1'b0) bad_ren++;
      if (done === 1'b1) begin
        n_done++;
        n_cyc = c;
      end
      if (rst) break;
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        k++;
        if (k == st0) stall_left = ln0;
        else if (k == st1) stall_left = ln1;
        else if (k == st2) stall_left = ln2;
      end else if (!bus.in_valid && stall_left > 0) begin
        stall_left--;
      end
      if (done === 1'b1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0055;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got busy/done/ready=%b required 000", {busy, done, bus.in_ready});
    end
    checks++;
    if (bus.mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_ren got %b required 0", bus.mem_ren);
    end
    checks++;
    if ({bus.mac_valid, bus.mac_last} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mac_flags got %b required 00", {bus.mac_valid, bus.mac_last});
    end
    checks++;
    if (bus.mac_input !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mac_input got %h required 0000", bus.mac_input);
    end
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_stall_cnt got %0d required 0", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    mon_beats = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      start = (i == 0); bus.in_valid = 1'b1; bus.in_data = DW'(i);
      @(negedge clk);
      checks++;
      if (busy !== (i >= 1 && i <= 32)) begin
        errors++;
        $display("FAIL b2b_busy cyc=%0d got %b required %b", i, busy, (i >= 1 && i <= 32));
      end
      checks++;
      if (done !== (i == 32)) begin
        errors++;
        $display("FAIL b2b_done cyc=%0d got %b required %b", i, done, (i == 32));
      end
      checks++;
      if (bus.mac_valid !== (i >= 2 && i <= 31)) begin
        errors++;
        $display("FAIL b2b_mac_valid cyc=%0d got %b required %b", i, bus.mac_valid,
                 (i >= 2 && i <= 31));
      end
      checks++;
      if (bus.mac_last !== (i == 31)) begin
        errors++;
        $display("FAIL b2b_mac_last cyc=%0d got %b required %b", i, bus.mac_last, (i == 31));
      end
      checks++;
      if (bus.in_ready !== (i >= 1 && i <= 30)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc=%0d got %b required %b", i, bus.in_ready,
                 (i >= 1 && i <= 30));
      end
      if (i >= 1 && i <= 30) begin
        checks++;
        if (bus.mem_radd !== AW'(i - 1) || bus.mem_ren !== 1'b1) begin
          errors++;
          $display("FAIL b2b_read cyc=%0d got ren=%b radd=%0d required ren=1 radd=%0d", i,
                   bus.mem_ren, bus.mem_radd, i - 1);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (mon_beats !== NW || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_beat_count got %0d pending=%0d required %0d pending=0", mon_beats,
               sb.size(), NW);
    end
  endtask

  task automatic test_stalls();
    int nd, nc, br;
    mon_beats = 0;
    run_seq(3, 2, 10, 1, 29, 5, -1, -1, nd, nc, br);
    checks++;
    if (nd !== 1 || nc !== 40) begin
      errors++;
      $display("FAIL stall_done got n=%0d cyc=%0d required n=1 cyc=40", nd, nc);
    end
    checks++;
    if (br !== 0) begin
      errors++;
      $display("FAIL stall_mem_ren got %0d reads while stalled required 0", br);
    end
    checks++;
    if (mon_beats !== NW || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_beat_count got %0d required %0d", mon_beats, NW);
    end
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin
      errors++;
      $display("FAIL stall_cnt_done got %0d required 8", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin
      errors++;
      $display("FAIL stall_cnt_hold got %0d required 8", stall_cnt);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    int nd, nc, br;
    mon_beats = 0;
    run_seq(-1, 0, -1, 0, -1, 0, 12, -1, nd, nc, br);
    checks++;
    if (nd !== 1 || nc !== 32) begin
      errors++;
      $display("FAIL swb_done got n=%0d cyc=%0d required n=1 cyc=32", nd, nc);
    end
    checks++;
    if (mon_beats !== NW || sb.size() != 0) begin
      errors++;
      $display("FAIL swb_beat_count got %0d required %0d", mon_beats, NW);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, busy, bus.mac_valid} !== 3'b000) begin
        errors++;
        $display("FAIL swb_after got done/busy/valid=%b required 000",
                 {done, busy, bus.mac_valid});
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nd, nc, br;
    mon_beats = 0;
    run_seq(-1, 0, -1, 0, -1, 0, -1, 17, nd, nc, br);
    checks++;
    if (nd !== 0 || mon_beats !== 17) begin
      errors++;
      $display("FAIL rmr_partial got done=%0d beats=%0d required done=0 beats=17", nd,
               mon_beats);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({done, busy, bus.mac_valid, bus.mem_ren} !== 4'b0000) begin
        errors++;
        $display("FAIL rmr_after got done/busy/valid/ren=%b required 0000",
                 {done, busy, bus.mac_valid, bus.mem_ren});
      end
    end
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmr_stall_cnt got %0d required 0", stall_cnt);
    end
`endif
    mon_beats = 0;
    run_seq(-1, 0, -1, 0, -1, 0, -1, -1, nd, nc, br);
    checks++;
    if (nd !== 1 || mon_beats !== NW || sb.size() != 0) begin
      errors++;
      $display("FAIL rmr_rerun got done=%0d beats=%0d required done=1 beats=%0d", nd,
               mon_beats, NW);
    end
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0; bus.in_valid = 1'b1; bus.in_data = DW'(16'h0A00 + i);
      @(negedge clk);
      checks++;
      if (bus.mem_ren !== 1'b0) begin
        errors++;
        $display("FAIL idle_mem_ren got %b required 0", bus.mem_ren);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_ready got %b required 0", bus.in_ready);
      end
      checks++;
      if (bus.mac_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_mac_valid got %b required 0", bus.mac_valid);
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_consecutive();
    int nd, nc, br;
    mon_beats = 0;
    run_seq(3, 2, 10, 1, 29, 5, -1, -1, nd, nc, br);
    checks++;
    if (nd !== 1 || nc !== 40) begin
      errors++;
      $display("FAIL cons_first got n=%0d cyc=%0d required n=1 cyc=40", nd, nc);
    end
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin
      errors++;
      $display("FAIL cons_stall_first got %0d required 8", stall_cnt);
    end
`endif
    run_seq(-1, 0, -1, 0, -1, 0, -1, -1, nd, nc, br);
    checks++;
    if (nd !== 1 || nc !== 32) begin
      errors++;
      $display("FAIL cons_second got n=%0d cyc=%0d required n=1 cyc=32", nd, nc);
    end
    checks++;
    if (mon_beats !== 2 * NW || sb.size() != 0) begin
      errors++;
      $display("FAIL cons_beat_count got %0d required %0d", mon_beats, 2 * NW);
    end
`ifdef WSEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cons_stall_second got %0d required 0", stall_cnt);
    end
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NW; k++) rom[k] = 16'hFA91 + DW'(k * 16'h1D3B);
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_back_to_back();
    test_stalls();
    test_start_while_busy();
    test_reset_mid_run();
    test_idle_valid();
    test_consecutive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Sequences one neuron's weight memory (W_Mem_* family: 1-cycle registered read, `ren`/`radd`/`wout`) against an incoming activation stream.
- Drives the memory read port and emits aligned {weight, input} beats to the neuron's MAC, with a last-beat flag and a done pulse.
- One instance per neuron, between the layer input bus and the MAC.

Parameters:
- numWeight, 30, number of weights per neuron; also the number of beats per run.
- addressWidth, $clog2(numWeight), width of the memory read address.
- dataWidth, 16, width of weights and inputs (signed fixed point; passed through unmodified).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a run; honoured only in IDLE.
- busy  output  1  high in RUN, LAST and DONE.
- in_valid  input  1  activation beat present.
- in_ready  output  1  sequencer accepts a beat; combinational, equals (state==RUN).
- in_data  input  dataWidth  activation value.
- mem_ren  output  1  weight memory read enable; combinational, equals in_valid & in_ready.
- mem_radd  output  addressWidth  weight memory read address; equals the address counter.
- mem_wout  input  dataWidth  weight memory read data; valid 1 cycle after mem_ren.
- mac_valid  output  1  MAC beat valid.
- mac_weight  output  dataWidth  weight for this beat; combinational pass-through of mem_wout.
- mac_input  output  dataWidth  activation for this beat; registered.
- mac_last  output  1  marks beat numWeight-1.
- done  output  1  single-cycle pulse at the end of a run.

Behaviour:
Reset:
- State = IDLE; address counter = 0.
- Registered outputs cleared: mac_valid=0, mac_last=0, mac_input=0, done=0.
- Therefore busy=0, in_ready=0, mem_ren=0.
- Reset mid-run abandons the run immediately: no done pulse, no further MAC beats, state = IDLE the cycle after rst.

States:
- IDLE: start=1 -> RUN; address counter cleared to 0.
- RUN: on each cycle with in_valid=1, the beat is accepted:
  - mem_ren=1, mem_radd=address counter.
  - in_data captured into mac_input.
  - Address counter increments.
  - If the accepted address == numWeight-1 -> LAST and the counter wraps to 0.
- In RUN, a cycle with in_valid=0 is a stall: address held, mem_ren=0, no beat produced.
- LAST: one cycle in which the final MAC beat appears; -> DONE unconditionally.
- DONE: done=1 for exactly this cycle; -> IDLE.

Beat timing:
- Beat accepted at cycle t produces mac_valid=1 at t+1, with mac_weight=W[addr], mac_input=in_data(t).
- mac_last=1 only on the beat for address numWeight-1.
- mac_valid is the registered copy of mem_ren; mac_last is the registered copy of (mem_ren & addr==numWeight-1).

Run-length and latency rules:
- Exactly numWeight beats per run, in ascending address order 0..numWeight-1.
- No address is skipped or repeated regardless of stall pattern.
- Minimum run latency, start to done: numWeight+3 cycles (1 cycle IDLE->RUN, numWeight accept cycles, LAST, DONE).

Boundary conditions:
- start while busy: ignored; the run is not restarted.
- start and rst in the same cycle: rst wins.
- in_valid while not in RUN: ignored; in_ready=0, so the producer must hold the beat.
- in_valid at the final address: LAST is entered; the next in_valid is not accepted until the next run.
- mac_weight is only meaningful while mac_valid=1.
- Memory write port: untouched (write side is ROM-initialised).

Optional Feature:
- Macro: WSEQ_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, width 16.
  - Counts RUN cycles with in_valid=0 during the current run.
  - Cleared on rst and on IDLE->RUN.
  - Saturates at 16'hFFFF.
  - Holds its value from LAST through IDLE, until the next start.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Back-to-back run (numWeight=30): rst 2 cycles; start at cycle 5; in_valid=1 continuously; in_data=k+1 for beat k.
  -> mem_radd 0..29 on cycles 6..35.
  -> mac_valid cycles 7..36, each with mac_input=k+1 and mac_weight equal to the ROM word k (beat 0 = 16'hFA91).
  -> mac_last only at cycle 36; done at cycle 37; busy 6..37.
- Stalls: drop in_valid after beats 3, 10 and 29 for 2, 1 and 5 cycles.
  -> Address holds across each stall; still exactly 30 beats, in order.
  -> With WSEQ_STALL_CNT_EN, stall_cnt=8 after done.
- start while busy: pulse start at beat 12.
  -> No restart; beats 13..29 continue; single done pulse.
- Reset mid-run: rst at beat 17.
  -> mac_valid=0 and busy=0 from the next cycle, no done.
  -> A new start gives beats 0..29 again from address 0.
- in_valid in IDLE: in_valid=1 for 10 cycles with no start.
  -> mem_ren=0, in_ready=0, mac_valid=0 throughout.
- Two consecutive runs: start asserted again in the cycle after done.
  -> Second run begins at address 0 with identical beat sequence.
  -> stall_cnt (if enabled) restarts at 0.
